// File: rtl/change_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | change_pkg : shared types and helpers for the change dispenser             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package change_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHK    = 3'd1,
        D_DROP = 3'd2,
        D_REL  = 3'd3,
        N_DROP = 3'd4,
        N_REL  = 3'd5,
        DONE   = 3'd6,
        FLT    = 3'd7
    } state_e;

    // Coin values in 5-cent units.
    localparam int unsigned NICKEL          = 1;
    localparam int unsigned DIME            = 2;
    localparam int unsigned DIME_AS_NICKELS = DIME / NICKEL;

    // Dimes always go out before nickels; nothing left means the request is complete.
    function automatic state_e next_coin(input logic [1:0] dimes_left,
                                         input logic [2:0] nickels_left);
        if (dimes_left != 2'd0) begin
            return D_DROP;
        end else if (nickels_left != 3'd0) begin
            return N_DROP;
        end
        return DONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/change_dispenser_inventory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coin_inventory : saturating up/down coin counter with reset preset         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module coin_inventory #(
    parameter int CNT_W = 4,
    parameter int INIT  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A simultaneous load and dec cancel out, even when the counter is full.
    always_comb begin
        cnt_d = cnt_q;
        if (load && !dec) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec && !load) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= CNT_W'(INIT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | change_dispenser : pays owed change one coin at a time via hopper req/ack  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module change_dispenser
    import change_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int INIT_NICKELS = 8,
    parameter int INIT_DIMES   = 8,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic             return5,
    input  logic             return10,
    input  logic             return2_10,
    input  logic             hopper_ack,
    input  logic             load_nickel,
    input  logic             load_dime,
    output logic             drop_nickel,
    output logic             drop_dime,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] nickel_cnt,
    output logic [CNT_W-1:0] dime_cnt
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic             ret5_q, ret5_d;
    logic             ret10_q, ret10_d;
    logic             ret2_q, ret2_d;
    logic [1:0]       dimes_owed_q, dimes_owed_d;
    logic [2:0]       nickels_owed_q, nickels_owed_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fault_q, fault_d;

    logic       accept;
    logic       tmo_hit;
    logic       dime_dec;
    logic       nickel_dec;
    logic [1:0] dimes_req;
    logic [1:0] plan_dimes;
    logic [2:0] plan_nickels;
    logic       plan_short;

    assign accept     = (state_q == IDLE) && req && !fault_q;
    assign tmo_hit    = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
    assign dime_dec   = (state_q == D_DROP) && hopper_ack;
    assign nickel_dec = (state_q == N_DROP) && hopper_ack;

    // Missing dimes become two nickels each; the whole plan must be payable or none of it is.
    always_comb begin
        dimes_req = {1'b0, ret10_q} + {ret2_q, 1'b0};
        if (32'(dime_cnt) < 32'(dimes_req)) begin
            plan_dimes = 2'(dime_cnt);
        end else begin
            plan_dimes = dimes_req;
        end
        plan_nickels = 3'(ret5_q) + 3'(DIME_AS_NICKELS * (dimes_req - plan_dimes));
        plan_short   = 32'(nickel_cnt) < 32'(plan_nickels);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ret5_q         <= 1'b0;
            ret10_q        <= 1'b0;
            ret2_q         <= 1'b0;
            dimes_owed_q   <= 2'd0;
            nickels_owed_q <= 3'd0;
            tmo_q          <= '0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            ret5_q         <= ret5_d;
            ret10_q        <= ret10_d;
            ret2_q         <= ret2_d;
            dimes_owed_q   <= dimes_owed_d;
            nickels_owed_q <= nickels_owed_d;
            tmo_q          <= tmo_d;
            fault_q        <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept) state_d = CHK;
            CHK:    state_d = plan_short ? FLT : next_coin(plan_dimes, plan_nickels);
            D_DROP: if (hopper_ack) state_d = D_REL;
                    else if (tmo_hit) state_d = FLT;
            D_REL:  if (!hopper_ack) state_d = next_coin(dimes_owed_q, nickels_owed_q);
                    else if (tmo_hit) state_d = FLT;
            N_DROP: if (hopper_ack) state_d = N_REL;
                    else if (tmo_hit) state_d = FLT;
            N_REL:  if (!hopper_ack) state_d = next_coin(dimes_owed_q, nickels_owed_q);
                    else if (tmo_hit) state_d = FLT;
            DONE:   state_d = IDLE;
            FLT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ret5_d         = ret5_q;
        ret10_d        = ret10_q;
        ret2_d         = ret2_q;
        dimes_owed_d   = dimes_owed_q;
        nickels_owed_d = nickels_owed_q;
        if (accept) begin
            ret5_d  = return5;
            ret10_d = return10;
            ret2_d  = return2_10;
        end
        if (state_q == CHK) begin
            dimes_owed_d   = plan_dimes;
            nickels_owed_d = plan_nickels;
        end
        if (dime_dec) begin
            dimes_owed_d = dimes_owed_q - 2'd1;
        end
        if (nickel_dec) begin
            nickels_owed_d = nickels_owed_q - 3'd1;
        end
        // Per-coin wait budget restarts on every state change.
        tmo_d   = (state_d != state_q) ? '0 : tmo_q + TMO_W'(1);
        fault_d = fault_q || (state_d == FLT);
    end

    always_comb begin
        drop_dime   = (state_q == D_DROP);
        drop_nickel = (state_q == N_DROP);
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        fault       = fault_q;
    end

    coin_inventory #(
        .CNT_W (CNT_W),
        .INIT  (INIT_NICKELS)
    ) u_nickels (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_nickel),
        .dec     (nickel_dec),
        .cnt     (nickel_cnt)
    );

    coin_inventory #(
        .CNT_W (CNT_W),
        .INIT  (INIT_DIMES)
    ) u_dimes (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_dime),
        .dec     (dime_dec),
        .cnt     (dime_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_change_dispenser : randomized scoreboard bench for change_dispenser     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_change_dispenser;

    localparam int CNT_W   = 4;
    localparam int INIT_N  = 8;
    localparam int INIT_D  = 8;
    localparam int ACK_TMO = 15;
    localparam int CMAX    = 15;

    localparam int EV_DIME   = 0;
    localparam int EV_NICKEL = 1;
    localparam int EV_DONE   = 2;
    localparam int EV_FAULT  = 3;

    typedef struct {
        int kind;
        int n;
        int d;
    } ev_t;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b1;
    logic             req        = 1'b0;
    logic             return5    = 1'b0;
    logic             return10   = 1'b0;
    logic             return2_10 = 1'b0;
    logic             hopper_ack = 1'b0;
    logic             ld_n_main  = 1'b0;
    logic             ld_n_hop   = 1'b0;
    logic             load_dime  = 1'b0;
    logic             load_nickel;
    logic             drop_nickel;
    logic             drop_dime;
    logic             busy;
    logic             done;
    logic             fault;
    logic [CNT_W-1:0] nickel_cnt;
    logic [CNT_W-1:0] dime_cnt;

    assign load_nickel = ld_n_main | ld_n_hop;

    int  m_n     = INIT_N;
    int  m_d     = INIT_D;
    bit  m_fault = 1'b0;
    ev_t sb[$];
    int  coinc_n  = 0;
    bit  coinc_en = 1'b0;
    bit  hop_en   = 1'b1;
    int  hop_dmin = 2;
    int  hop_dmax = 2;
    int  n_checks = 0;
    int  n_fail   = 0;

    change_dispenser #(
        .CNT_W        (CNT_W),
        .INIT_NICKELS (INIT_N),
        .INIT_DIMES   (INIT_D),
        .ACK_TIMEOUT  (ACK_TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .return5     (return5),
        .return10    (return10),
        .return2_10  (return2_10),
        .hopper_ack  (hopper_ack),
        .load_nickel (load_nickel),
        .load_dime   (load_dime),
        .drop_nickel (drop_nickel),
        .drop_dime   (drop_dime),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .nickel_cnt  (nickel_cnt),
        .dime_cnt    (dime_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int k, input int n, input int d);
        ev_t e;
        e.kind = k;
        e.n    = n;
        e.d    = d;
        sb.push_back(e);
    endtask

    task automatic pop_ev(input int kind, output bit ok, output ev_t e);
        ok = 1'b0;
        e.kind = -1; e.n = 0; e.d = 0;
        if (sb.size() == 0) begin
            chk("unexpected_event", kind, -1);
        end else begin
            e  = sb.pop_front();
            ok = 1'b1;
            chk("event_kind", kind, e.kind);
        end
    endtask

    // Monitor: turns DUT output edges into events and checks them against the scoreboard.
    initial begin : monitor
        bit  pd, pn, pf, ok;
        int  run;
        ev_t e;
        pd = 0; pn = 0; pf = 0; run = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pd = 0; pn = 0; pf = 0; run = 0;
            end else begin
                if ((drop_dime && !pd) || (drop_nickel && !pn))
                    chk("drop_overlap", int'(drop_dime && drop_nickel), 0);
                if (drop_dime && !pd)   pop_ev(EV_DIME, ok, e);
                if (drop_nickel && !pn) pop_ev(EV_NICKEL, ok, e);
                if (drop_dime || drop_nickel) begin
                    run++;
                end else if (pd || pn) begin
                    if (fault) chk("ack_timeout_len", run, ACK_TMO);
                    run = 0;
                end
                if (done) begin
                    pop_ev(EV_DONE, ok, e);
                    if (ok && e.kind == EV_DONE) begin
                        chk("done_nickel_cnt", int'(nickel_cnt), e.n + coinc_n);
                        chk("done_dime_cnt", int'(dime_cnt), e.d);
                        chk("done_busy", int'(busy), 1);
                    end
                end
                if (fault && !pf) begin
                    pop_ev(EV_FAULT, ok, e);
                    if (ok && e.kind == EV_FAULT) begin
                        chk("fault_nickel_cnt", int'(nickel_cnt), e.n + coinc_n);
                        chk("fault_dime_cnt", int'(dime_cnt), e.d);
                        chk("fault_drops_low", int'(drop_dime || drop_nickel), 0);
                    end
                end
                pd = drop_dime;
                pn = drop_nickel;
                pf = fault;
            end
        end
    end

    // Hopper: acks each commanded coin after a random delay, releases after another.
    initial begin : hopper
        int d;
        forever begin
            @(negedge clk);
            if (hop_en && reset_n && (drop_dime || drop_nickel) && !hopper_ack) begin
                d = $urandom_range(hop_dmax, hop_dmin);
                repeat (d) @(negedge clk);
                if (drop_dime || drop_nickel) begin
                    hopper_ack = 1'b1;
                    if (coinc_en && drop_nickel) begin
                        ld_n_hop = 1'b1;
                        coinc_n++;
                    end
                    @(negedge clk);
                    ld_n_hop = 1'b0;
                    for (int i = 0; i < 40 && (drop_dime || drop_nickel); i++) @(negedge clk);
                    d = $urandom_range(hop_dmax, hop_dmin);
                    repeat (d) @(negedge clk);
                    hopper_ack = 1'b0;
                end
            end
        end
    end

    task automatic do_reset(input bit mid_cycle);
        if (mid_cycle) begin
            @(posedge clk);
            #2;
        end else begin
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        chk("rst_drop_nickel", int'(drop_nickel), 0);
        chk("rst_drop_dime", int'(drop_dime), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_nickel_cnt", int'(nickel_cnt), INIT_N);
        chk("rst_dime_cnt", int'(dime_cnt), INIT_D);
        sb.delete();
        m_n        = INIT_N;
        m_d        = INIT_D;
        m_fault    = 1'b0;
        coinc_n    = 0;
        hopper_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) fin = 1'b1;
        end
        chk("payout_complete", int'(fin), 1);
    endtask

    task automatic send_req(input bit r5, input bit r10, input bit r2);
        @(negedge clk);
        req = 1'b1; return5 = r5; return10 = r10; return2_10 = r2;
        @(negedge clk);
        req = 1'b0; return5 = 1'b0; return10 = 1'b0; return2_10 = 1'b0;
    endtask

    // Reference model: plan the payout from the inventory with plain arithmetic.
    task automatic issue_req(input bit r5, input bit r10, input bit r2, input bit no_ack);
        int dreq, dpay, npay;
        bit ignored;
        ignored = m_fault;
        if (!ignored) begin
            dreq = r10 + 2 * r2;
            dpay = (m_d < dreq) ? m_d : dreq;
            npay = r5 + 2 * (dreq - dpay);
            if (m_n < npay) begin
                m_fault = 1'b1;
                push_ev(EV_FAULT, m_n, m_d);
            end else if (no_ack) begin
                if (dpay > 0)      push_ev(EV_DIME, 0, 0);
                else if (npay > 0) push_ev(EV_NICKEL, 0, 0);
                m_fault = 1'b1;
                push_ev(EV_FAULT, m_n, m_d);
            end else begin
                repeat (dpay) push_ev(EV_DIME, 0, 0);
                repeat (npay) push_ev(EV_NICKEL, 0, 0);
                m_d -= dpay;
                m_n -= npay;
                push_ev(EV_DONE, m_n, m_d);
            end
        end
        coinc_n = 0;
        send_req(r5, r10, r2);
        if (ignored) begin
            repeat (4) @(negedge clk);
            chk("ignored_req_busy", int'(busy), 0);
            chk("ignored_req_fault", int'(fault), 1);
        end else begin
            wait_idle();
        end
        m_n += coinc_n;
        coinc_n = 0;
    endtask

    task automatic idle_load(input bit nickel, input int cycles);
        @(negedge clk);
        for (int i = 0; i < cycles; i++) begin
            if (nickel) begin
                ld_n_main = 1'b1;
                m_n = (m_n < CMAX) ? m_n + 1 : CMAX;
            end else begin
                load_dime = 1'b1;
                m_d = (m_d < CMAX) ? m_d + 1 : CMAX;
            end
            @(negedge clk);
        end
        ld_n_main = 1'b0;
        load_dime = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit seen;
        do_reset(1'b0);

        // Single nickel, then dime + nickel, then dime exhaustion with substitution.
        issue_req(1, 0, 0, 0);
        issue_req(1, 1, 0, 0);
        issue_req(0, 0, 0, 0);
        repeat (3) issue_req(0, 0, 1, 0);
        issue_req(0, 0, 1, 0);
        chk("subst_dime_cnt", int'(dime_cnt), m_d);
        chk("subst_nickel_cnt", int'(nickel_cnt), m_n);

        // Drain nickels to 1, then a dime request that cannot be covered.
        while (m_n > 1) issue_req(1, 0, 0, 0);
        issue_req(0, 1, 0, 0);
        issue_req(1, 0, 0, 0);
        do_reset(1'b0);

        // Hopper never acks: per-coin timeout.
        hop_en = 1'b0;
        issue_req(0, 1, 0, 1);
        chk("tmo_busy", int'(busy), 0);
        do_reset(1'b0);

        // Reset in the middle of a payout.
        hop_en = 1'b1;
        issue_req(1, 0, 1, 0);
        hop_en = 1'b0;
        push_ev(EV_DIME, 0, 0);
        send_req(0, 0, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = drop_dime;
        end
        chk("midpay_drop_seen", int'(seen), 1);
        repeat (3) @(negedge clk);
        do_reset(1'b1);
        hop_en = 1'b1;

        // Saturating refill and load coincident with a payout decrement.
        idle_load(1'b1, 10);
        chk("load_sat_nickel", int'(nickel_cnt), m_n);
        idle_load(1'b0, 3);
        chk("load_dime", int'(dime_cnt), m_d);
        coinc_en = 1'b1;
        issue_req(1, 0, 0, 0);
        issue_req(1, 0, 1, 0);
        coinc_en = 1'b0;

        // Randomized traffic.
        hop_dmin = 0;
        hop_dmax = 5;
        for (int it = 0; it < 200; it++) begin
            if (m_fault && ($urandom_range(3, 0) != 0)) do_reset(1'b0);
            if ($urandom_range(2, 0) == 0)
                idle_load(1'($urandom_range(1, 0)), $urandom_range(4, 1));
            coinc_en = ($urandom_range(3, 0) == 0);
            issue_req(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      1'($urandom_range(1, 0)), 1'b0);
            coinc_en = 1'b0;
        end
        chk("final_nickel_cnt", int'(nickel_cnt), m_n);
        chk("final_dime_cnt", int'(dime_cnt), m_d);
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
